// File: rtl/imc_pkg.sv
// ---------------------------------------------------------------------------
// imc_pkg
// Shared definitions for the in-memory-compute result path.
//   state_t            : collector FSM states (IDLE, COLLECT, DRAIN)
//   ARRAY_SIZE         : number of array columns / accumulator entries
//   ARRAY_DEPTH        : column index width (2**ARRAY_DEPTH == ARRAY_SIZE)
//   ADC_BITS           : width of one ADC conversion
//   ACC_WIDTH          : per-column accumulator width
//   DATA_WIDTH         : readback word width (matches the instruction size)
//   RD_TAG_MSB/LSB     : bit range of the column tag inside a readback word
// ---------------------------------------------------------------------------
package imc_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    localparam int ARRAY_SIZE  = 16;
    localparam int ARRAY_DEPTH = 4;
    localparam int ADC_BITS    = 4;
    localparam int ACC_WIDTH   = 12;
    localparam int DATA_WIDTH  = 32;

    localparam int RD_TAG_MSB  = 31;
    localparam int RD_TAG_LSB  = 28;

endpackage

// File: rtl/adc_result_collector_acc_sat_add.sv
// ---------------------------------------------------------------------------
// acc_sat_add
// Combinational saturating adder: accumulator value plus one unsigned ADC
// conversion. The result clamps to all-ones when the true sum does not fit.
//   i_acc      : current accumulator value (ACC_WIDTH bits)
//   i_add      : ADC conversion to add (ADC_BITS bits, unsigned)
//   o_sum      : saturated sum (ACC_WIDTH bits)
//   o_overflow : high when the sum was clamped
// ---------------------------------------------------------------------------
module acc_sat_add #(
    parameter int ACC_WIDTH = imc_pkg::ACC_WIDTH,
    parameter int ADC_BITS  = imc_pkg::ADC_BITS
) (
    input  logic [ACC_WIDTH-1:0] i_acc,
    input  logic [ADC_BITS-1:0]  i_add,
    output logic [ACC_WIDTH-1:0] o_sum,
    output logic                 o_overflow
);

    logic [ACC_WIDTH:0] w_wideSum;

    // One extra bit of headroom catches the carry out; a set carry means the
    // sum exceeded the accumulator range and the output is pinned at max.
    always_comb begin
        w_wideSum  = {1'b0, i_acc} + (ACC_WIDTH + 1)'(i_add);
        o_overflow = w_wideSum[ACC_WIDTH];
        o_sum      = o_overflow ? '1 : w_wideSum[ACC_WIDTH-1:0];
    end

endmodule

// File: rtl/adc_result_collector.sv
// ---------------------------------------------------------------------------
// adc_result_collector
// Captures one ADC sample per column over an inclusive column sweep, stores
// it per column (overwrite or saturating accumulate), then drains the stored
// values as tagged words over a valid/ready port.
//   clk, rst            : clock, asynchronous active-low reset
//   i_mac_start         : one-cycle pulse starting a collection
//   i_col_start/end     : inclusive column range of the sweep
//   i_accumulate        : 1 = add to stored value, 0 = overwrite
//   i_clear_acc         : zero all accumulators and sticky flags (IDLE only)
//   i_adc_valid/data    : one ADC conversion per valid cycle
//   o_busy              : high in COLLECT or DRAIN
//   o_done              : one-cycle pulse after last word or on range error
//   o_range_err         : sticky, start column above end column
//   o_overflow          : sticky, an accumulation saturated
//   o_rd_valid/data     : readback word {tag[31:28], 0..., acc value}
//   i_rd_ready          : consumer accepts the current word
// ---------------------------------------------------------------------------
module adc_result_collector #(
    parameter int ARRAY_SIZE  = imc_pkg::ARRAY_SIZE,
    parameter int ARRAY_DEPTH = imc_pkg::ARRAY_DEPTH,
    parameter int ADC_BITS    = imc_pkg::ADC_BITS,
    parameter int ACC_WIDTH   = imc_pkg::ACC_WIDTH,
    parameter int DATA_WIDTH  = imc_pkg::DATA_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   i_mac_start,
    input  logic [ARRAY_DEPTH-1:0] i_col_start,
    input  logic [ARRAY_DEPTH-1:0] i_col_end,
    input  logic                   i_accumulate,
    input  logic                   i_clear_acc,
    input  logic                   i_adc_valid,
    input  logic [ADC_BITS-1:0]    i_adc_data,
    output logic                   o_busy,
    output logic                   o_done,
    output logic                   o_range_err,
    output logic                   o_overflow,
    output logic                   o_rd_valid,
    output logic [DATA_WIDTH-1:0]  o_rd_data,
    input  logic                   i_rd_ready
);

    import imc_pkg::*;

    localparam int TagWidth = RD_TAG_MSB - RD_TAG_LSB + 1;

    state_t                 r_state;
    state_t                 w_nextState;
    logic [ARRAY_DEPTH-1:0] r_startCol;
    logic [ARRAY_DEPTH-1:0] r_endCol;
    logic [ARRAY_DEPTH-1:0] r_curCol;
    logic [ARRAY_DEPTH-1:0] r_rdPtr;
    logic                   r_accumulate;
    logic                   r_done;
    logic                   r_rangeErr;
    logic                   r_overflow;
    logic [ACC_WIDTH-1:0]   r_acc [ARRAY_SIZE];

    logic                   w_startOk;
    logic                   w_lastSample;
    logic                   w_lastWord;
    logic [ACC_WIDTH-1:0]   w_satSum;
    logic                   w_satOvf;

    assign w_startOk    = (i_col_start <= i_col_end);
    assign w_lastSample = (r_state == COLLECT) && i_adc_valid && (r_curCol == r_endCol);
    assign w_lastWord   = (r_state == DRAIN) && i_rd_ready && (r_rdPtr == r_endCol);

    acc_sat_add #(
        .ACC_WIDTH (ACC_WIDTH),
        .ADC_BITS  (ADC_BITS)
    ) u_satAdd (
        .i_acc      (r_acc[r_curCol]),
        .i_add      (i_adc_data),
        .o_sum      (w_satSum),
        .o_overflow (w_satOvf)
    );

    // State register; reset drops straight to IDLE so an interrupted sweep
    // never produces a done pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    // Next-state and output decode. rd_valid is simply "in DRAIN", which
    // gives the one-cycle gap after the last sample, and rd_data is a pure
    // function of registered state so it cannot move while a word is stalled.
    always_comb begin
        w_nextState = r_state;
        o_busy      = 1'b0;
        o_rd_valid  = 1'b0;
        o_rd_data   = '0;
        unique case (r_state)
            IDLE: begin
                if (i_mac_start && w_startOk) begin
                    w_nextState = COLLECT;
                end
            end
            COLLECT: begin
                o_busy = 1'b1;
                if (w_lastSample) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                o_busy                          = 1'b1;
                o_rd_valid                      = 1'b1;
                o_rd_data[ACC_WIDTH-1:0]        = r_acc[r_rdPtr];
                o_rd_data[RD_TAG_MSB:RD_TAG_LSB] = TagWidth'(r_rdPtr);
                if (w_lastWord) begin
                    w_nextState = IDLE;
                end
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // Datapath: sweep pointers, accumulator file and sticky flags. In IDLE
    // the clear is written before the start/range checks so that a clear and
    // a start in the same cycle behave as "clear, then start".
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_startCol   <= '0;
            r_endCol     <= '0;
            r_curCol     <= '0;
            r_rdPtr      <= '0;
            r_accumulate <= 1'b0;
            r_done       <= 1'b0;
            r_rangeErr   <= 1'b0;
            r_overflow   <= 1'b0;
            for (int i = 0; i < ARRAY_SIZE; i++) begin
                r_acc[i] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                IDLE: begin
                    if (i_clear_acc) begin
                        r_rangeErr <= 1'b0;
                        r_overflow <= 1'b0;
                        for (int i = 0; i < ARRAY_SIZE; i++) begin
                            r_acc[i] <= '0;
                        end
                    end
                    if (i_mac_start) begin
                        if (w_startOk) begin
                            r_startCol   <= i_col_start;
                            r_endCol     <= i_col_end;
                            r_curCol     <= i_col_start;
                            r_accumulate <= i_accumulate;
                        end else begin
                            r_rangeErr <= 1'b1;
                            r_done     <= 1'b1;
                        end
                    end
                end
                COLLECT: begin
                    if (i_adc_valid) begin
                        r_acc[r_curCol] <= r_accumulate ? w_satSum : ACC_WIDTH'(i_adc_data);
                        if (r_accumulate && w_satOvf) begin
                            r_overflow <= 1'b1;
                        end
                        if (r_curCol == r_endCol) begin
                            r_rdPtr <= r_startCol;
                        end else begin
                            r_curCol <= r_curCol + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (i_rd_ready) begin
                        if (r_rdPtr == r_endCol) begin
                            r_done <= 1'b1;
                        end else begin
                            r_rdPtr <= r_rdPtr + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_done      = r_done;
    assign o_range_err = r_rangeErr;
    assign o_overflow  = r_overflow;

endmodule

// File: doc/adc_result_collector.md
Name: adc_result_collector

Overview:
- Downstream of the instruction decoder / MAC sequencer; consumes ADC conversions produced during a MAC_OPERATION sweep.
- Captures one ADC sample per column over [col_start..col_end] and stores it per column, either overwriting or accumulating across row-tile MACs.
- Drains results as tagged 32-bit words over a valid/ready port for Wishbone readback.
- Tells the sequencer it is done so the instruction fetch halt can be released.

Parameters:
- ARRAY_SIZE, 16, number of columns (accumulator entries).
- ARRAY_DEPTH, 4, column index width; 2**ARRAY_DEPTH == ARRAY_SIZE.
- ADC_BITS, 4, width of one ADC conversion.
- ACC_WIDTH, 12, accumulator width per column; must satisfy ADC_BITS <= ACC_WIDTH <= 28.
- DATA_WIDTH, 32, readback word width; equals INSTRUCTION_SIZE.

Ports:
- clk, in, 1, clock.
- rst, in, 1, asynchronous reset, active-low.
- mac_start, in, 1, one-cycle pulse that begins a collection.
- col_start, in, ARRAY_DEPTH, first column of the sweep.
- col_end, in, ARRAY_DEPTH, last column of the sweep (inclusive).
- accumulate, in, 1, 1 = add to stored value; 0 = overwrite.
- clear_acc, in, 1, synchronous zeroing of all accumulators and overflow; honoured in IDLE only.
- adc_valid, in, 1, one conversion present on adc_data.
- adc_data, in, ADC_BITS, unsigned conversion result.
- busy, out, 1, high in COLLECT or DRAIN.
- done, out, 1, one-cycle pulse when the last word drains or a range error occurs.
- range_err, out, 1, sticky; set when col_start > col_end.
- overflow, out, 1, sticky; set when any accumulation saturates.
- rd_valid, out, 1, rd_data holds a result word.
- rd_data, out, DATA_WIDTH, [31:28] = column index, [ACC_WIDTH-1:0] = accumulator value, all other bits 0.
- rd_ready, in, 1, consumer accepts the word.

Behaviour:
- Reset (async, rst low):
  - state = IDLE; all accumulators = 0.
  - busy, done, range_err, overflow, rd_valid = 0; rd_data = 0.
  - Reset mid-COLLECT or mid-DRAIN aborts immediately; no done pulse.
- IDLE:
  - On mac_start with col_start <= col_end: latch start, end and accumulate; cur_col = col_start; go to COLLECT. busy rises the next cycle.
  - On mac_start with col_start > col_end: set range_err, pulse done the next cycle, stay IDLE, accumulators untouched.
  - clear_acc zeroes all accumulators and clears overflow and range_err. If mac_start is asserted in the same cycle, clear applies first, then the start is taken.
  - adc_valid is ignored.
- COLLECT:
  - Each cycle with adc_valid: acc[cur_col] = accumulate ? sat(acc[cur_col] + zext(adc_data)) : zext(adc_data).
  - Saturation clamps to 2**ACC_WIDTH-1 and sets overflow.
  - If cur_col == end_col, go to DRAIN with rd_ptr = start_col; otherwise cur_col++.
  - No wrap-around is possible because end_col >= start_col.
  - mac_start and clear_acc are ignored while busy.
  - Back-to-back adc_valid every cycle is supported.
- DRAIN:
  - rd_valid = 1 starting the cycle after the last sample is accepted; rd_data presents acc[rd_ptr].
  - rd_data must stay stable while rd_valid && !rd_ready.
  - On rd_valid && rd_ready: if rd_ptr == end_col, drop rd_valid, pulse done and go to IDLE (busy low the same cycle done is high). Otherwise rd_ptr++.
  - adc_valid in DRAIN is ignored (dropped, not queued).
- Latency:
  - mac_start to COLLECT: 1 cycle.
  - Last sample to rd_valid: 1 cycle.
  - Final handshake to done: 1 cycle.
  - Minimum total for N columns with constant ready = 1 + N + N + 1 cycles.
- Single-column sweep (col_start == col_end) produces exactly one sample and one readback word.

Decomposition:
- Shared package (imc_pkg):
  - State enum {IDLE, COLLECT, DRAIN}.
  - Default ARRAY_SIZE, ARRAY_DEPTH, ADC_BITS, ACC_WIDTH.
  - RD_TAG_MSB = 31 and RD_TAG_LSB = 28 for the readback column tag.
- One sub-module, acc_sat_add: a combinational saturating add of ACC_WIDTH + ADC_BITS that returns the sum and an overflow bit.
- The accumulator file stays inline as a register array.

Test Plan:
- Overwrite sweep: mac_start, cols 2..5, accumulate = 0; adc samples 3, 7, 15, 1 with ready = 1 -> words 0x20000003, 0x30000007, 0x4000000F, 0x50000001; done pulses once; overflow = 0.
- Accumulate across tiles: two sweeps on cols 0..1, samples (5, 6) then (4, 10), second sweep with accumulate = 1 -> second drain returns 0x00000009, 0x10000010.
- Saturation: preload acc[7] = 0xFFE; sweep col 7, accumulate = 1, sample 9 -> word 0x70000FFF; overflow = 1 and stays set until clear_acc in IDLE.
- Range error: col_start = 9, col_end = 4 -> range_err = 1; done pulses the next cycle; busy stays 0; rd_valid never rises.
- Backpressure: cols 14..15, rd_ready held low for 5 cycles -> rd_data stable showing col 14 for all 5 cycles; words then delivered in order; extra adc_valid pulses in DRAIN do not change values.
- Reset mid-COLLECT: after 2 of 4 samples, pulse rst low -> busy = 0, rd_valid = 0, no done pulse; a fresh sweep then returns only the new samples.
